wcrc_packer: RTL and testbench
==============================

WCRC_PACKER -- requirements
Module: wcrc_packer

Interface
REQ-001 SHALL have parameter M, default 8, number of weight slots per packed bus.
REQ-002 SHALL have parameter n, default 16, weight width in bits.
REQ-003 SHALL have parameter cl, default 8, CRC width in bits.
REQ-004 SHALL have parameter POLY, default 8'h07, CRC generator polynomial (x^8+x^2+x+1, implicit top bit).
REQ-005 SHALL have port: clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port: w_valid  input  1  weight offered.
REQ-008 SHALL have port: w_data  input  n  weight value.
REQ-009 SHALL have port: w_ready  output  1  packer accepts weight this cycle.
REQ-010 SHALL have port: wcrc_valid  output  1  packed bus complete.
REQ-011 SHALL have port: wcrc_ready  input  1  consumer takes packed bus.
REQ-012 SHALL have port: wcrc  output  M*(n+cl)  packed bus of M words {weight, crc}.
REQ-013 SHALL have port: slot  output  clog2(M)+1  number of slots filled.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, STORE, FULL.
REQ-015 IDLE: w_ready=1; w_valid&&w_ready latches w_data, clears CRC register to 0, bit counter to 0, goes to SHIFT.
REQ-016 SHIFT: one weight bit per cycle, MSB first; crc <= {crc[cl-2:0],1'b0} ^ (POLY & {cl{crc[cl-1]^bit}}); after n cycles go to STORE.
REQ-017 STORE: writes {weight, crc} into slot index `slot`, slot 0 at wcrc[n+cl-1:0], slot M-1 at top; increments slot; goes to FULL if slot reaches M, else IDLE.
REQ-018 Latency: accept to store SHALL be exactly n+1 cycles; w_ready SHALL be 0 in SHIFT, STORE and FULL.
REQ-019 FULL: wcrc_valid=1, wcrc stable; on wcrc_ready=1 SHALL clear slot to 0 and go to IDLE in the same edge; wcrc contents retained until overwritten.
REQ-020 wcrc_ready while wcrc_valid=0 SHALL be ignored.
REQ-021 w_valid while w_ready=0 SHALL be ignored (no buffering, no error).
REQ-022 Word layout SHALL match the neuron's Wcrc check: weight in bits [n+cl-1:cl], CRC in [cl-1:0].

Reset
REQ-023 rst=1 SHALL force IDLE, slot=0, wcrc=0, wcrc_valid=0, w_ready=1 after the edge, aborting any in-flight weight.
REQ-024 rst SHALL take priority over all handshakes in the same cycle.

Configuration
REQ-025 With WCRC_FAULT_INJECT_EN defined, SHALL add inputs inj_en (1) and inj_mask (cl); inj_mask is latched with the weight when inj_en=1 at accept and XORed into the CRC at STORE.
REQ-026 Without WCRC_FAULT_INJECT_EN, those ports SHALL not exist and CRC SHALL be stored unmodified.

Structure
REQ-027 Package wcrc_pkg SHALL hold default M, n, cl, POLY and the FSM state enum.
REQ-028 Serial CRC step SHALL be sub-module crc_serial (bit in, shift enable, clear, crc out).

Verification
REQ-029 Reset then 8 weights 16'h0000 back-to-back -> each store after 17 cycles, wcrc_valid after 8th, wcrc = all zeros.
REQ-030 Weight 16'h0001 into slot 0 -> wcrc[23:0] = 24'h000107.
REQ-031 Hold wcrc_ready=0 in FULL for 10 cycles with w_valid=1 -> w_ready=0, wcrc unchanged; wcrc_ready=1 -> slot=0, IDLE next cycle.
REQ-032 Assert rst at SHIFT cycle 5 of slot 3 -> slot=0, wcrc=0, w_ready=1 after edge; next weight lands in slot 0.
REQ-033 WCRC_FAULT_INJECT_EN, inj_mask=8'h01 on 16'h0001 -> stored word 24'h000106; neuron-side check flags it invalid.
REQ-034 wcrc_ready pulsed in IDLE with slot=2 -> ignored, slot stays 2.

Source files
------------

// File: rtl/wcrc_pkg.sv
// Shared defaults and FSM state encoding for the weight/CRC packer.
package wcrc_pkg;

  localparam int unsigned M_DEF  = 8;
  localparam int unsigned N_DEF  = 16;
  localparam int unsigned CL_DEF = 8;
  localparam logic [7:0]  POLY_DEF = 8'h07;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STORE = 2'd2,
    FULL  = 2'd3
  } state_t;

endpackage

// File: rtl/wcrc_packer_crc_serial.sv
// Bit-serial CRC register, MSB-first, one input bit per enabled cycle.
module crc_serial
  import wcrc_pkg::*;
#(
  parameter int unsigned      cl   = CL_DEF,
  parameter logic [cl-1:0]    POLY = POLY_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic          bit_in,
  output logic [cl-1:0] crc
);

  logic fb;

  always_comb begin
    fb = crc[cl-1] ^ bit_in;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= {crc[cl-2:0], 1'b0} ^ (POLY & {cl{fb}});
    end
  end

endmodule

// File: rtl/wcrc_packer.sv
// Packs M weights, each followed by its serial CRC, into one wide bus.
// Optional build macro WCRC_FAULT_INJECT_EN adds inj_en/inj_mask CRC corruption ports.
module wcrc_packer
  import wcrc_pkg::*;
#(
  parameter int unsigned   M    = M_DEF,
  parameter int unsigned   n    = N_DEF,
  parameter int unsigned   cl   = CL_DEF,
  parameter logic [cl-1:0] POLY = POLY_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      w_valid,
  input  logic [n-1:0]              w_data,
  output logic                      w_ready,
  output logic                      wcrc_valid,
  input  logic                      wcrc_ready,
  output logic [M*(n+cl)-1:0]       wcrc,
`ifdef WCRC_FAULT_INJECT_EN
  input  logic                      inj_en,
  input  logic [cl-1:0]             inj_mask,
`endif
  output logic [$clog2(M):0]        slot
);

  localparam int unsigned W  = n + cl;
  localparam int unsigned SW = $clog2(M) + 1;
  localparam int unsigned CW = $clog2(n + 1);

  state_t          state, state_nxt;
  logic [n-1:0]    wreg;
  logic [n-1:0]    sreg;
  logic [CW-1:0]   cnt;
  logic [cl-1:0]   crc;
  logic [cl-1:0]   crc_store;
  logic [W-1:0]    word;
  logic            accept;
  logic            last_bit;
  logic            shift_en;
`ifdef WCRC_FAULT_INJECT_EN
  logic [cl-1:0]   mask;
`endif

  crc_serial #(
    .cl   (cl),
    .POLY (POLY)
  ) u_crc (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .en     (shift_en),
    .bit_in (sreg[n-1]),
    .crc    (crc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (w_valid)    state_nxt = SHIFT;
      SHIFT: if (last_bit)   state_nxt = STORE;
      STORE: state_nxt = (slot == SW'(M - 1)) ? FULL : IDLE;
      FULL:  if (wcrc_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_ready    = (state == IDLE);
    wcrc_valid = (state == FULL);
    shift_en   = (state == SHIFT);
    accept     = (state == IDLE) && w_valid;
    last_bit   = (cnt == CW'(n - 1));
`ifdef WCRC_FAULT_INJECT_EN
    crc_store  = crc ^ mask;
`else
    crc_store  = crc;
`endif
    word       = {wreg, crc_store};
  end

  // sreg feeds the CRC MSB-first while wreg keeps the original weight for STORE.
  always_ff @(posedge clk) begin
    if (rst) begin
      wreg <= '0;
      sreg <= '0;
      cnt  <= '0;
      slot <= '0;
      wcrc <= '0;
`ifdef WCRC_FAULT_INJECT_EN
      mask <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (w_valid) begin
            wreg <= w_data;
            sreg <= w_data;
            cnt  <= '0;
`ifdef WCRC_FAULT_INJECT_EN
            mask <= inj_en ? inj_mask : '0;
`endif
          end
        end
        SHIFT: begin
          sreg <= {sreg[n-2:0], 1'b0};
          cnt  <= cnt + CW'(1);
        end
        STORE: begin
          for (int unsigned i = 0; i < M; i++) begin
            if (slot == SW'(i)) wcrc[i*W +: W] <= word;
          end
          slot <= slot + SW'(1);
        end
        FULL: begin
          if (wcrc_ready) slot <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wcrc_packer.sv
// Directed self-checking bench for wcrc_packer (default parameters).
module tb_wcrc_packer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         w_valid = 1'b0;
  logic [15:0]  w_data = '0;
  logic         w_ready;
  logic         wcrc_valid;
  logic         wcrc_ready = 1'b0;
  logic [191:0] wcrc;
  logic [3:0]   slot;
`ifdef WCRC_FAULT_INJECT_EN
  logic         inj_en = 1'b0;
  logic [7:0]   inj_mask = '0;
`endif

  int errors = 0;
  int checks = 0;

  wcrc_packer dut (
    .clk        (clk),
    .rst        (rst),
    .w_valid    (w_valid),
    .w_data     (w_data),
    .w_ready    (w_ready),
    .wcrc_valid (wcrc_valid),
    .wcrc_ready (wcrc_ready),
    .wcrc       (wcrc),
`ifdef WCRC_FAULT_INJECT_EN
    .inj_en     (inj_en),
    .inj_mask   (inj_mask),
`endif
    .slot       (slot)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offers one weight and returns cycles from the accept edge to the store edge.
  task automatic load(input logic [15:0] d, output int cyc);
    int guard;
    logic [3:0] s0;
    guard = 0;
    while (w_ready !== 1'b1 && guard < 50) begin
      tick;
      guard++;
    end
    checks++;
    if (guard >= 50) begin
      errors++;
      $display("FAIL load_wait: w_ready=%b expected 1 within 50 cycles", w_ready);
    end
    s0 = slot;
    w_valid = 1'b1;
    w_data  = d;
    tick;
    w_valid = 1'b0;
    cyc = 0;
    while (slot === s0 && cyc < 40) begin
      tick;
      cyc++;
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    checks++; if (w_ready !== 1'b1) begin errors++; $display("FAIL reset_w_ready: got %b expected 1", w_ready); end
    checks++; if (wcrc_valid !== 1'b0) begin errors++; $display("FAIL reset_wcrc_valid: got %b expected 0", wcrc_valid); end
    checks++; if (slot !== 4'd0) begin errors++; $display("FAIL reset_slot: got %0d expected 0", slot); end
    checks++; if (wcrc !== 192'd0) begin errors++; $display("FAIL reset_wcrc: got %h expected 0", wcrc); end
  endtask

  task automatic test_back_to_back_zeros;
    int cyc;
    for (int k = 0; k < 8; k++) begin
      load(16'h0000, cyc);
      checks++;
      if (cyc !== 17) begin errors++; $display("FAIL zeros_latency[%0d]: got %0d expected 17", k, cyc); end
    end
    checks++; if (wcrc_valid !== 1'b1) begin errors++; $display("FAIL zeros_valid: got %b expected 1", wcrc_valid); end
    checks++; if (slot !== 4'd8) begin errors++; $display("FAIL zeros_slot: got %0d expected 8", slot); end
    checks++; if (wcrc !== 192'd0) begin errors++; $display("FAIL zeros_wcrc: got %h expected 0", wcrc); end
    checks++; if (w_ready !== 1'b0) begin errors++; $display("FAIL zeros_w_ready: got %b expected 0", w_ready); end
    wcrc_ready = 1'b1;
    tick;
    wcrc_ready = 1'b0;
    checks++; if (slot !== 4'd0) begin errors++; $display("FAIL zeros_release_slot: got %0d expected 0", slot); end
    checks++; if (w_ready !== 1'b1) begin errors++; $display("FAIL zeros_release_ready: got %b expected 1", w_ready); end
  endtask

  task automatic test_crc_values;
    int cyc;
    do_reset;
    load(16'h0001, cyc);
    checks++; if (wcrc[23:0] !== 24'h000107) begin errors++; $display("FAIL crc_0001: got %h expected 000107", wcrc[23:0]); end
    checks++; if (slot !== 4'd1) begin errors++; $display("FAIL crc_slot1: got %0d expected 1", slot); end
    load(16'h8000, cyc);
    checks++; if (wcrc[47:24] !== 24'h8000B6) begin errors++; $display("FAIL crc_8000: got %h expected 8000b6", wcrc[47:24]); end
    load(16'h0100, cyc);
    checks++; if (wcrc[71:48] !== 24'h010015) begin errors++; $display("FAIL crc_0100: got %h expected 010015", wcrc[71:48]); end
    checks++; if (wcrc[23:0] !== 24'h000107) begin errors++; $display("FAIL crc_slot0_kept: got %h expected 000107", wcrc[23:0]); end
  endtask

  task automatic test_ready_in_idle;
    wcrc_ready = 1'b1;
    tick;
    wcrc_ready = 1'b0;
    checks++; if (slot !== 4'd2 + 4'd1) begin errors++; $display("FAIL idle_ready_slot: got %0d expected 3", slot); end
    checks++; if (wcrc_valid !== 1'b0) begin errors++; $display("FAIL idle_ready_valid: got %b expected 0", wcrc_valid); end
    checks++; if (w_ready !== 1'b1) begin errors++; $display("FAIL idle_ready_w_ready: got %b expected 1", w_ready); end
  endtask

  task automatic test_full_hold;
    int cyc;
    logic [191:0] exp_bus;
    exp_bus = {{5{24'h000107}}, 24'h010015, 24'h8000B6, 24'h000107};
    for (int k = 0; k < 5; k++) load(16'h0001, cyc);
    checks++; if (wcrc_valid !== 1'b1) begin errors++; $display("FAIL full_valid: got %b expected 1", wcrc_valid); end
    w_valid = 1'b1;
    w_data  = 16'hFFFF;
    for (int k = 0; k < 10; k++) begin
      tick;
      checks++;
      if (w_ready !== 1'b0 || wcrc !== exp_bus) begin
        errors++;
        $display("FAIL full_hold[%0d]: w_ready=%b wcrc=%h expected w_ready=0 wcrc=%h", k, w_ready, wcrc, exp_bus);
      end
    end
    w_valid = 1'b0;
    wcrc_ready = 1'b1;
    tick;
    wcrc_ready = 1'b0;
    checks++; if (slot !== 4'd0) begin errors++; $display("FAIL full_release_slot: got %0d expected 0", slot); end
    checks++; if (w_ready !== 1'b1) begin errors++; $display("FAIL full_release_ready: got %b expected 1", w_ready); end
    checks++; if (wcrc_valid !== 1'b0) begin errors++; $display("FAIL full_release_valid: got %b expected 0", wcrc_valid); end
    checks++; if (wcrc !== exp_bus) begin errors++; $display("FAIL full_retained: got %h expected %h", wcrc, exp_bus); end
  endtask

  task automatic test_reset_midflight;
    int cyc;
    do_reset;
    for (int k = 0; k < 3; k++) load(16'h0001, cyc);
    w_valid = 1'b1;
    w_data  = 16'hABCD;
    tick;
    w_valid = 1'b0;
    for (int k = 0; k < 5; k++) tick;
    checks++; if (w_ready !== 1'b0) begin errors++; $display("FAIL mid_in_shift: w_ready=%b expected 0", w_ready); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++; if (slot !== 4'd0) begin errors++; $display("FAIL mid_rst_slot: got %0d expected 0", slot); end
    checks++; if (wcrc !== 192'd0) begin errors++; $display("FAIL mid_rst_wcrc: got %h expected 0", wcrc); end
    checks++; if (w_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b expected 1", w_ready); end
    load(16'h0001, cyc);
    checks++; if (cyc !== 17) begin errors++; $display("FAIL mid_next_latency: got %0d expected 17", cyc); end
    checks++; if (wcrc !== {168'd0, 24'h000107}) begin errors++; $display("FAIL mid_next_slot0: got %h expected slot0 000107 only", wcrc); end
    // rst wins over an offered weight in the same cycle
    rst = 1'b1;
    w_valid = 1'b1;
    w_data = 16'h1234;
    tick;
    rst = 1'b0;
    w_valid = 1'b0;
    tick;
    checks++; if (w_ready !== 1'b1) begin errors++; $display("FAIL rst_priority: w_ready=%b expected 1", w_ready); end
  endtask

`ifdef WCRC_FAULT_INJECT_EN
  task automatic test_fault_inject;
    int cyc;
    do_reset;
    inj_en = 1'b1;
    inj_mask = 8'h01;
    load(16'h0001, cyc);
    inj_en = 1'b0;
    checks++; if (wcrc[23:0] !== 24'h000106) begin errors++; $display("FAIL inject_word: got %h expected 000106", wcrc[23:0]); end
    checks++; if (wcrc[7:0] === 8'h07) begin errors++; $display("FAIL inject_detect: crc %h matches clean crc 07", wcrc[7:0]); end
    inj_mask = 8'hFF;
    load(16'h0001, cyc);
    checks++; if (wcrc[47:24] !== 24'h000107) begin errors++; $display("FAIL inject_disabled: got %h expected 000107", wcrc[47:24]); end
  endtask
`endif

  initial begin
    test_reset;
    test_back_to_back_zeros;
    test_crc_values;
    test_ready_in_idle;
    test_full_hold;
    test_reset_midflight;
`ifdef WCRC_FAULT_INJECT_EN
    test_fault_inject;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
